// File: rtl/inen_4bit_pkg.sv
// Shared constants and types for the inen_4bit enabled input register.
package inen_4bit_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef logic [DEFAULT_WIDTH-1:0] data_t;

    localparam data_t DEFAULT_RESET_VAL = '0;

endpackage

// File: rtl/inen_4bit_cell.sv
// One-bit enabled flop with asynchronous active-low clear to a fixed value.
module inen_4bit_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/inen_4bit.sv
// Input-enabled register bank with a one-cycle load strobe.
// Define INEN4BIT_PARITY_EN to add a registered even-parity output of data_out.
module inen_4bit
    import inen_4bit_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             Inen,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             loaded
`ifdef INEN4BIT_PARITY_EN
    ,
    output logic             parity
`endif
);

    // Data path: one enabled flop per bit, each clearing to its reset bit.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        inen_4bit_cell #(
            .RST_VAL (RESET_VAL[i])
        ) u_cell (
            .clk (clk),
            .clr (clr),
            .en  (Inen),
            .d   (data_in[i]),
            .q   (data_out[i])
        );
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            loaded <= 1'b0;
        end else begin
            loaded <= Inen;
        end
    end

`ifdef INEN4BIT_PARITY_EN
    // Parity tracks the value being loaded so it lands on the same edge as data_out.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            parity <= ^RESET_VAL;
        end else if (Inen) begin
            parity <= ^data_in;
        end
    end
`endif

endmodule

// File: tb/tb_inen_4bit.sv
// Scoreboard bench for inen_4bit: directed scenarios plus randomized traffic.
module tb_inen_4bit;
    import inen_4bit_pkg::*;

    localparam int unsigned W = DEFAULT_WIDTH;

    typedef struct {
        logic [W-1:0] data;
        logic         ld;
        logic         par;
        string        tag;
    } exp_t;

    logic         clk;
    logic         clr;
    logic         Inen;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic         loaded;
`ifdef INEN4BIT_PARITY_EN
    logic         parity;
`endif

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    // Reference state: what the register should hold after the last sampled edge.
    logic [W-1:0] m_data;
    logic         m_ld;

    inen_4bit dut (
        .clk      (clk),
        .clr      (clr),
        .Inen     (Inen),
        .data_in  (data_in),
        .data_out (data_out),
        .loaded   (loaded)
`ifdef INEN4BIT_PARITY_EN
        ,
        .parity   (parity)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic even_par(input logic [W-1:0] v);
        return logic'($countones(v) % 2);
    endfunction

    // Drive one cycle's inputs at the falling edge and queue the expected post-edge state.
    task automatic step(input logic c, input logic en, input logic [W-1:0] d, input string tag);
        exp_t e;
        @(negedge clk);
        clr     = c;
        Inen    = en;
        data_in = d;
        if (!c) begin
            m_data = DEFAULT_RESET_VAL;
            m_ld   = 1'b0;
        end else if (en) begin
            m_data = d;
            m_ld   = 1'b1;
        end else begin
            m_ld   = 1'b0;
        end
        e.data = m_data;
        e.ld   = m_ld;
        e.par  = even_par(m_data);
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Monitor: one observation per rising edge, compared against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.tag, "_data"},   32'(data_out), 32'(e.data));
                check({e.tag, "_loaded"}, 32'(loaded),   32'(e.ld));
`ifdef INEN4BIT_PARITY_EN
                check({e.tag, "_parity"}, 32'(parity),   32'(e.par));
`endif
            end
        end
    end

    initial begin
        clr     = 1'b1;
        Inen    = 1'b0;
        data_in = '0;
        m_data  = DEFAULT_RESET_VAL;
        m_ld    = 1'b0;

        #1 clr = 1'b0;
        #1;
        check("reset_t0_data",   32'(data_out), 32'(DEFAULT_RESET_VAL));
        check("reset_t0_loaded", 32'(loaded),   32'd0);

        // Held in reset: clock edges and data/enable changes ignored.
        step(1'b0, 1'b0, 4'b0000, "rst_hold0");
        step(1'b0, 1'b0, 4'b0011, "rst_hold1");
        step(1'b0, 1'b0, 4'b1010, "rst_hold2");
        step(1'b0, 1'b1, 4'b1111, "rst_override");

        // Hold with enable low.
        step(1'b1, 1'b0, 4'b0011, "hold0");
        step(1'b1, 1'b0, 4'b1010, "hold1");

        // Back-to-back loads, including an identical reload.
        step(1'b1, 1'b1, 4'b1111, "load_f");
        step(1'b1, 1'b1, 4'b1001, "load_9");
        step(1'b1, 1'b1, 4'b0011, "load_3");
        step(1'b1, 1'b1, 4'b1010, "load_a");
        step(1'b1, 1'b1, 4'b1010, "reload_a");

        // Async reset between edges, then reset held against an active enable.
        @(posedge clk);
        #3 clr = 1'b0;
        m_data = DEFAULT_RESET_VAL;
        m_ld   = 1'b0;
        #1;
        check("async_rst_data",   32'(data_out), 32'(DEFAULT_RESET_VAL));
        check("async_rst_loaded", 32'(loaded),   32'd0);
        step(1'b0, 1'b1, 4'b1111, "rst_en0");
        step(1'b0, 1'b1, 4'b1111, "rst_en1");

        // Release with enable high: first edge loads.
        step(1'b1, 1'b1, 4'b1001, "release");

        // Enable glitch between edges is ignored.
        step(1'b1, 1'b0, 4'b0110, "glitch");
        #2 Inen = 1'b1;
        #1 Inen = 1'b0;

        // data_in change after the capturing edge has no effect.
        step(1'b1, 1'b1, 4'b0101, "load_5");
        @(posedge clk);
        #2 data_in = 4'b1010;
        #1;
        check("no_transp_data", 32'(data_out), 32'd5);
        step(1'b1, 1'b0, 'x, "hold_x");
        step(1'b1, 1'b0, 4'b1100, "hold_after_x");

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), W'($urandom), "rand");
        end

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inen_4bit.md
INEN_4BIT -- requirements
Module: inen_4bit

Interface
REQ-001 Parameter: WIDTH, 4, data path width in bits (legal range 1..32).
REQ-002 Parameter: RESET_VAL, all zeros, WIDTH-bit value loaded into data_out on reset.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: clr  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-005 Port: Inen  input  1  input enable; 1 = load data_in on the next rising clk edge, 0 = hold.
REQ-006 Port: data_in  input  WIDTH  data to capture.
REQ-007 Port: data_out  output  WIDTH  registered output.
REQ-008 Port: loaded  output  1  registered strobe; 1 for exactly one cycle after each edge that performed a load.
REQ-009 Port (only with INEN4BIT_PARITY_EN): parity  output  1  registered even parity (XOR) of data_out.

Function
REQ-010 Rising clk edge with clr=1 and Inen=1: data_out SHALL take data_in as sampled at that edge; latency is one edge.
REQ-011 Rising clk edge with clr=1 and Inen=0: data_out SHALL hold its value, whatever data_in does.
REQ-012 data_in changes between edges SHALL have no effect on data_out; the output is never combinationally transparent.
REQ-013 loaded SHALL be 1 after an edge where Inen=1 and clr=1, and 0 after an edge where Inen=0.
REQ-014 Continuous Inen=1 SHALL reload on every edge and keep loaded at 1; reloading an identical value still sets loaded=1.
REQ-015 Inen SHALL be sampled only at rising clk edges; pulses between edges SHALL be ignored.
REQ-016 clr=0 SHALL override Inen regardless of timing; clr=0 and Inen=1 together SHALL leave the register in reset.
REQ-017 X/Z on data_in while Inen=0 SHALL NOT propagate to data_out.

Reset
REQ-018 clr falling to 0 SHALL immediately, without waiting for clk, force data_out=RESET_VAL, loaded=0 and (if built) parity=^RESET_VAL.
REQ-019 While clr=0, all outputs SHALL hold their reset values and clk edges SHALL be ignored.
REQ-020 After clr rises to 1, the first rising clk edge SHALL behave per REQ-010/011, with no extra dead cycle.
REQ-021 Reset asserted mid-operation SHALL discard the held value; nothing SHALL be restored after reset is released.

Configuration
REQ-022 Macro INEN4BIT_PARITY_EN: when defined, the parity port and its register SHALL exist and update on the same edge as data_out; when undefined, the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-023 A shared package inen_4bit_pkg SHALL hold the default WIDTH constant (4), the default RESET_VAL constant (all zeros) and a WIDTH-bit data typedef.
REQ-024 One sub-module, inen_4bit_cell, SHALL implement a 1-bit enabled flop with async active-low clear; inen_4bit SHALL instantiate WIDTH copies via generate and SHALL keep the loaded and parity logic at top level.

Verification
REQ-025 Reset: clr=0, Inen=0, data_in=0000, then 0011, then 1010 over several clocks -> data_out=0000 and loaded=0 throughout.
REQ-026 Hold: clr=1, Inen=0, data_out=0000, data_in=0011 then 1010 -> data_out stays 0000 and loaded=0.
REQ-027 Load sequence: clr=1, Inen=1, data_in 1111 -> 1001 -> 0011 -> 1010, one value per cycle -> data_out follows one edge later, loaded=1 each cycle, parity 0, 0, 0, 0.
REQ-028 Async reset: data_out=1010, drive clr=0 between clk edges -> data_out=0000 and loaded=0 before the next edge; with Inen=1 and data_in=1111, data_out stays 0000.
REQ-029 Release: clr 0->1 with Inen=1 and data_in=1001 -> data_out=1001 after the first rising edge, loaded=1.
REQ-030 Glitch: Inen pulses high between edges only, data_in=0110 -> data_out unchanged and loaded=0.
